// File: rtl/cam_ctrl.sv
// cam_ctrl: command sequencer and entry manager for a DEPTH-entry CAM.
// Each command runs IDLE -> MATCH -> RESP; table and response update together on leaving MATCH.
module cam_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int KEY_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [KEY_WIDTH-1:0]  cmd_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);
  typedef enum logic [1:0] {IDLE, MATCH, RESP} state_t;
  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  state_t                             r_state;
  logic [1:0]                         r_op;
  logic [KEY_WIDTH-1:0]               r_key;
  logic [DEPTH-1:0][KEY_WIDTH-1:0]    r_keys;
  logic [DEPTH-1:0]                   r_valid;
  logic                               w_hit;
  logic                               w_free;
  logic [ADDR_WIDTH-1:0]              w_hit_idx;
  logic [ADDR_WIDTH-1:0]              w_free_idx;
  assign full  = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = count == '0;
  // Descending scan so the lowest matching/free index is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_free     = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_keys[i] == r_key) begin
        w_hit     = 1'b1;
        w_hit_idx = ADDR_WIDTH'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = ADDR_WIDTH'(i);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= OP_LOOKUP;
      r_key     <= '0;
      r_keys    <= '0;
      r_valid   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_state   <= MATCH;
            r_op      <= cmd_op;
            r_key     <= cmd_key;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        MATCH: begin
          r_state   <= RESP;
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_addr  <= '0;
          rsp_err   <= 1'b0;
          case (r_op)
            OP_LOOKUP: begin
              rsp_hit  <= w_hit;
              rsp_addr <= w_hit_idx;
            end
            OP_INSERT: begin
              if (w_hit) begin
                rsp_hit  <= 1'b1;
                rsp_addr <= w_hit_idx;
              end else if (w_free) begin
                r_keys[w_free_idx]  <= r_key;
                r_valid[w_free_idx] <= 1'b1;
                rsp_addr            <= w_free_idx;
                count               <= count + 1'b1;
              end else begin
                rsp_err <= 1'b1;
              end
            end
            OP_DELETE: begin
              if (w_hit) begin
                r_valid[w_hit_idx] <= 1'b0;
                rsp_hit            <= 1'b1;
                rsp_addr           <= w_hit_idx;
                count              <= count - 1'b1;
              end else begin
                rsp_err <= 1'b1;
              end
            end
            default: begin
              r_valid <= '0;
              count   <= '0;
            end
          endcase
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed bench for cam_ctrl with a cycle-level table model and per-cycle compare.
module tb_cam_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_key = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_hit;
  logic [2:0] rsp_addr;
  logic       rsp_err;
  logic [3:0] count;
  logic       full;
  logic       empty;
  int total = 0;
  int bad = 0;
  cam_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: plain key/valid arrays plus the handshake timing.
  logic [7:0] mk [8];
  logic [7:0] mv;
  logic [1:0] p_op;
  logic [7:0] p_key;
  logic m_ready, m_busy, m_wait, m_rv;
  int e_hit, e_addr, e_err;
  function automatic int find_key(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (mv[i] && mk[i] == k) return i;
    return -1;
  endfunction
  function automatic int find_free();
    for (int i = 0; i < 8; i++) if (!mv[i]) return i;
    return -1;
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_wait <= 1'b0; m_rv <= 1'b0; mv <= '0;
      e_hit <= 0; e_addr <= 0; e_err <= 0;
    end else if (!m_busy) begin
      if (cmd_valid && m_ready) begin
        m_busy <= 1'b1; m_wait <= 1'b1; m_ready <= 1'b0; p_op <= cmd_op; p_key <= cmd_key;
      end else m_ready <= 1'b1;
    end else if (m_wait) begin
      m_wait <= 1'b0; m_rv <= 1'b1; e_hit <= 0; e_addr <= 0; e_err <= 0;
      case (p_op)
        2'd0: if (find_key(p_key) >= 0) begin e_hit <= 1; e_addr <= find_key(p_key); end
        2'd1: if (find_key(p_key) >= 0) begin e_hit <= 1; e_addr <= find_key(p_key); end
              else if (find_free() >= 0) begin
                mk[find_free()] <= p_key; mv[find_free()] <= 1'b1; e_addr <= find_free();
              end else e_err <= 1;
        2'd2: if (find_key(p_key) >= 0) begin
                mv[find_key(p_key)] <= 1'b0; e_hit <= 1; e_addr <= find_key(p_key);
              end else e_err <= 1;
        default: mv <= '0;
      endcase
    end else if (m_rv && rsp_ready) begin
      m_rv <= 1'b0; m_busy <= 1'b0; m_ready <= 1'b1;
    end
  end
  always @(negedge clk) begin
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    chk("rsp_valid", int'(rsp_valid), int'(m_rv));
    chk("count", int'(count), $countones(mv));
    chk("full", int'(full), int'($countones(mv) == 8));
    chk("empty", int'(empty), int'($countones(mv) == 0));
    if (m_rv) begin
      chk("rsp_hit", int'(rsp_hit), e_hit);
      chk("rsp_addr", int'(rsp_addr), e_addr);
      chk("rsp_err", int'(rsp_err), e_err);
    end
  end
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) chk({nm, "_accept_timeout"}, 0, 1);
  endtask
  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    if (!rsp_valid) chk({nm, "_rsp_timeout"}, 0, 1);
  endtask
  task automatic send(input string nm, input logic [1:0] op, input logic [7:0] key,
                      input int eh, input int ea, input int ee);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key;
    wait_ready(nm);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({nm, "_match_no_rsp"}, int'(rsp_valid), 0);
    @(negedge clk);
    chk({nm, "_rsp_at_2"}, int'(rsp_valid), 1);
    wait_rsp(nm);
    chk({nm, "_hit"}, int'(rsp_hit), eh);
    chk({nm, "_addr"}, int'(rsp_addr), ea);
    chk({nm, "_err"}, int'(rsp_err), ee);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_fields", int'({rsp_hit, rsp_addr, rsp_err}), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);
    send("ins11", 2'd1, 8'h11, 0, 0, 0);
    send("ins22", 2'd1, 8'h22, 0, 1, 0);
    send("ins33", 2'd1, 8'h33, 0, 2, 0);
    chk("count3", int'(count), 3);
    chk("not_empty", int'(empty), 0);
    send("lkp22", 2'd0, 8'h22, 1, 1, 0);
    send("lkp44", 2'd0, 8'h44, 0, 0, 0);
    send("reins22", 2'd1, 8'h22, 1, 1, 0);
    chk("count3_dedup", int'(count), 3);
    for (int i = 3; i < 8; i++) send("fill", 2'd1, 8'hA0 + 8'(i), 0, i, 0);
    chk("count8", int'(count), 8);
    chk("full8", int'(full), 1);
    send("ins99_full", 2'd1, 8'h99, 0, 0, 1);
    chk("count8_after_err", int'(count), 8);
    send("del_a5", 2'd2, 8'hA5, 1, 5, 0);
    chk("count7", int'(count), 7);
    chk("not_full", int'(full), 0);
    send("ins99_slot5", 2'd1, 8'h99, 0, 5, 0);
    chk("full_again", int'(full), 1);
    send("del77_absent", 2'd2, 8'h77, 0, 0, 1);
    chk("count8_del_absent", int'(count), 8);
    send("flush", 2'd3, 8'h00, 0, 0, 0);
    chk("count0_flush", int'(count), 0);
    chk("empty_flush", int'(empty), 1);
    send("lkp11_flushed", 2'd0, 8'h11, 0, 0, 0);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_key = 8'h11;
    wait_ready("bp");
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'd1; cmd_key = 8'h12;
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", int'(rsp_valid), 1);
      chk("bp_ready_low", int'(cmd_ready), 0);
      chk("bp_fields", int'({rsp_hit, rsp_addr, rsp_err}), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rsp_dropped", int'(rsp_valid), 0);
    chk("bp_ready_back", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("bp2");
    chk("bp2_fields", int'({rsp_hit, rsp_addr, rsp_err}), 0);
    @(posedge clk);
    @(negedge clk);
    chk("count1", int'(count), 1);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_key = 8'h55;
    wait_ready("rst_mid");
    @(posedge clk);
    #2 reset = 1'b1; cmd_valid = 1'b0;
    #1;
    chk("mid_cmd_ready", int'(cmd_ready), 0);
    chk("mid_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rsp_fields", int'({rsp_hit, rsp_addr, rsp_err}), 0);
    chk("mid_count", int'(count), 0);
    chk("mid_full_empty", int'({full, empty}), 1);
    @(negedge clk);
    reset = 1'b0;
    send("lkp55_after_rst", 2'd0, 8'h55, 0, 0, 0);
    send("lkp12_after_rst", 2'd0, 8'h12, 0, 0, 0);
    chk("count0_end", int'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
